stage_ifetch_prefetch: RTL

Parametrised instruction-fetch stage that owns the fetch PC. It prefetches opcodes from a 1-cycle synchronous instruction memory into a DEPTH-entry queue. It presents them to decode with the existing drdy/ack_in handshake and supports a redirect (loop jump) that squashes queued and in-flight fetches. It sits between instruction memory and the decode stage and replaces the external-PC, single-register fetch stage.

---
 rtl/stage_ifetch_prefetch.sv | 96 +++++++++
 1 files changed

// File: rtl/stage_ifetch_prefetch.sv
// Instruction-fetch stage: owns the fetch PC, prefetches opcodes from a 1-cycle
// synchronous instruction memory into a small queue, and supports redirects.
module stage_ifetch_prefetch #(
   parameter int                  A_WIDTH  = 12,
   parameter int                  D_WIDTH  = 8,
   parameter int                  DEPTH    = 4,
   parameter logic [A_WIDTH-1:0]  RESET_PC = '0,
   parameter logic [D_WIDTH-1:0]  NOP      = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pc_load,
   input  logic [A_WIDTH-1:0]           pc_target,
   output logic                         ice,
   output logic [A_WIDTH-1:0]           ia,
   input  logic [D_WIDTH-1:0]           id,
   output logic [D_WIDTH-1:0]           opcode,
   output logic [A_WIDTH-1:0]           opc_pc,
   output logic                         drdy,
   input  logic                         ack_in,
   output logic [$clog2(DEPTH):0]       level
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);

   logic [A_WIDTH-1:0] fpc;
   logic               inflight;
   logic [A_WIDTH-1:0] inflight_addr;
   logic [LW-1:0]      count;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [D_WIDTH-1:0] q_op [DEPTH];
   logic [A_WIDTH-1:0] q_pc [DEPTH];

   logic               push;
   logic               pop;
   logic [LW:0]        occupancy;

   always_comb begin
      drdy      = !reset && (count != '0);
      opcode    = drdy ? q_op[rd_ptr] : NOP;
      opc_pc    = drdy ? q_pc[rd_ptr] : '0;
      level     = reset ? '0 : count;
      pop       = drdy && ack_in && !pc_load;
      push      = inflight && !pc_load && !reset;
      // Reserve a slot for the read still in flight so the queue can never overflow.
      occupancy = {1'b0, count} + {{LW{1'b0}}, inflight} - {{LW{1'b0}}, pop};
      ice       = !reset && !pc_load && (occupancy < (LW+1)'(DEPTH));
      ia        = fpc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fpc           <= RESET_PC;
         inflight      <= 1'b0;
         inflight_addr <= '0;
      end else if (pc_load) begin
         fpc           <= pc_target;
         inflight      <= 1'b0;
      end else begin
         inflight <= ice;
         if (ice) begin
            fpc           <= fpc + 1'b1;
            inflight_addr <= fpc;
         end
      end
   end

   // A redirect flushes the whole queue, including a head that was being acked.
   always_ff @(posedge clk) begin
      if (reset || pc_load) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_op[wr_ptr] <= id;
         q_pc[wr_ptr] <= inflight_addr;
      end
   end

endmodule
